// File: rtl/c2c_stats_accum.sv
// rtl/c2c_stats_accum.sv - per-category event counters with saturating increment, clear FSM and 1-cycle read port
module c2c_stats_accum #(
    parameter int N_EV  = 16,
    parameter int CNT_W = 32,
    localparam int IDX_W = $clog2(N_EV + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_EV-1:0]  in_events,
    input  logic             clr_req,
    output logic             clr_busy,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_data,
    output logic [N_EV:0]    sat_flags
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state;
    logic              s1_valid;
    logic [N_EV-1:0]   s1_ev;
    logic [CNT_W-1:0]  cnt [N_EV+1];
    logic [N_EV:0]     hit;
    logic              accept;

    // Reset gates the handshake outputs so nothing is offered while reset is held.
    assign in_ready = (state == RUN) && !reset;
    assign clr_busy = (state != RUN) && !reset;
    assign accept   = in_valid && in_ready;

    // The total counter (index N_EV) counts every sample, even with no category hit.
    assign hit = s1_valid ? {1'b1, s1_ev} : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (clr_req) state <= DRAIN;
                DRAIN:   state <= CLEAR;
                CLEAR:   state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_ev    <= '0;
        end else begin
            s1_valid <= accept;
            if (accept)
                s1_ev <= in_events;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i <= N_EV; i++)
                cnt[i] <= '0;
            sat_flags <= '0;
        end else if (state == CLEAR) begin
            for (int i = 0; i <= N_EV; i++)
                cnt[i] <= '0;
            sat_flags <= '0;
        end else begin
            for (int i = 0; i <= N_EV; i++) begin
                if (hit[i]) begin
                    if (cnt[i] == CNT_MAX)
                        sat_flags[i] <= 1'b1;
                    else
                        cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Reads sample the pre-edge counter value, so a colliding increment is not seen.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                if (rd_idx <= IDX_W'(N_EV))
                    rd_data <= cnt[rd_idx];
                else
                    rd_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_c2c_stats_accum.sv
// tb/tb_c2c_stats_accum.sv - directed self-checking bench for c2c_stats_accum
module tb_c2c_stats_accum;

    logic        clock;
    logic        reset;

    logic        a_in_valid, a_in_ready, a_clr_req, a_clr_busy, a_rd_en, a_rd_valid;
    logic [15:0] a_in_events;
    logic [4:0]  a_rd_idx;
    logic [31:0] a_rd_data;
    logic [16:0] a_sat_flags;

    logic        b_in_valid, b_in_ready, b_clr_req, b_clr_busy, b_rd_en, b_rd_valid;
    logic [15:0] b_in_events;
    logic [4:0]  b_rd_idx;
    logic [3:0]  b_rd_data;
    logic [16:0] b_sat_flags;

    int vec_cnt = 0;
    int err_cnt = 0;

    c2c_stats_accum #(.N_EV(16), .CNT_W(32)) dut_a (
        .clock(clock), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_events(a_in_events),
        .clr_req(a_clr_req), .clr_busy(a_clr_busy),
        .rd_en(a_rd_en), .rd_idx(a_rd_idx), .rd_valid(a_rd_valid), .rd_data(a_rd_data),
        .sat_flags(a_sat_flags)
    );

    c2c_stats_accum #(.N_EV(16), .CNT_W(4)) dut_b (
        .clock(clock), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_events(b_in_events),
        .clr_req(b_clr_req), .clr_busy(b_clr_busy),
        .rd_en(b_rd_en), .rd_idx(b_rd_idx), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
        .sat_flags(b_sat_flags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic read_a(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        a_rd_en  = 1'b1;
        a_rd_idx = idx;
        step();
        a_rd_en = 1'b0;
        check({tag, "_valid"}, 64'(a_rd_valid), 64'(1));
        check(tag, 64'(a_rd_data), 64'(exp));
    endtask

    task automatic read_b(input string tag, input logic [4:0] idx, input logic [3:0] exp);
        b_rd_en  = 1'b1;
        b_rd_idx = idx;
        step();
        b_rd_en = 1'b0;
        check({tag, "_valid"}, 64'(b_rd_valid), 64'(1));
        check(tag, 64'(b_rd_data), 64'(exp));
    endtask

    initial begin
        reset = 1'b1;
        a_in_valid = 0; a_in_events = '0; a_clr_req = 0; a_rd_en = 0; a_rd_idx = '0;
        b_in_valid = 0; b_in_events = '0; b_clr_req = 0; b_rd_en = 0; b_rd_idx = '0;

        // Reset state
        step();
        step();
        check("rst_in_ready", 64'(a_in_ready), 64'(0));
        check("rst_clr_busy", 64'(a_clr_busy), 64'(0));
        check("rst_rd_valid", 64'(a_rd_valid), 64'(0));
        check("rst_rd_data", 64'(a_rd_data), 64'(0));
        check("rst_sat", 64'(a_sat_flags), 64'(0));
        reset = 1'b0;
        #1;
        check("rel_in_ready", 64'(a_in_ready), 64'(1));

        // Burst of 5 samples with categories 0 and 1
        a_in_valid  = 1'b1;
        a_in_events = 16'h0003;
        for (int i = 0; i < 5; i++) begin
            check("burst_in_ready", 64'(a_in_ready), 64'(1));
            step();
        end
        a_in_valid = 1'b0;
        check("burst_in_ready_end", 64'(a_in_ready), 64'(1));
        step();
        read_a("burst_c0", 5'd0, 32'd5);
        read_a("burst_c1", 5'd1, 32'd5);
        read_a("burst_c2", 5'd2, 32'd0);
        read_a("burst_tot", 5'd16, 32'd5);
        step();
        check("idle_rd_valid", 64'(a_rd_valid), 64'(0));
        check("idle_rd_hold", 64'(a_rd_data), 64'(5));

        // Read colliding with an increment of the same counter
        a_in_valid  = 1'b1;
        a_in_events = 16'h0008;
        step();
        a_in_valid = 1'b0;
        read_a("coll_pre", 5'd3, 32'd0);
        read_a("coll_post", 5'd3, 32'd1);

        // Out-of-range index
        read_a("oor", 5'd17, 32'd0);

        // Clear request coinciding with a sample
        a_in_valid  = 1'b1;
        a_in_events = 16'h0010;
        a_clr_req   = 1'b1;
        step();
        a_in_valid = 1'b0;
        a_clr_req  = 1'b0;
        check("drain_in_ready", 64'(a_in_ready), 64'(0));
        check("drain_busy", 64'(a_clr_busy), 64'(1));
        a_clr_req = 1'b1;
        step();
        a_clr_req = 1'b0;
        check("clear_in_ready", 64'(a_in_ready), 64'(0));
        check("clear_busy", 64'(a_clr_busy), 64'(1));
        read_a("clear_rd_c4", 5'd4, 32'd1);
        check("post_clr_in_ready", 64'(a_in_ready), 64'(1));
        check("post_clr_busy", 64'(a_clr_busy), 64'(0));
        read_a("post_clr_c0", 5'd0, 32'd0);
        read_a("post_clr_c4", 5'd4, 32'd0);
        read_a("post_clr_tot", 5'd16, 32'd0);
        check("post_clr_sat", 64'(a_sat_flags), 64'(0));
        check("post_clr_ignored_req", 64'(a_in_ready), 64'(1));

        // Saturation on the 4-bit instance
        b_in_valid  = 1'b1;
        b_in_events = 16'h0001;
        for (int i = 0; i < 17; i++)
            step();
        b_in_valid = 1'b0;
        step();
        read_b("sat_c0", 5'd0, 4'd15);
        read_b("sat_tot", 5'd16, 4'd15);
        read_b("sat_c1", 5'd1, 4'd0);
        check("sat_flags", 64'(b_sat_flags), 64'h10001);
        b_clr_req = 1'b1;
        step();
        b_clr_req = 1'b0;
        step();
        step();
        check("sat_cleared", 64'(b_sat_flags), 64'(0));
        read_b("sat_clr_c0", 5'd0, 4'd0);

        // Reset in DRAIN with a pending s1 sample
        a_in_valid  = 1'b1;
        a_in_events = 16'h0001;
        a_clr_req   = 1'b1;
        step();
        a_in_valid = 1'b0;
        a_clr_req  = 1'b0;
        check("rd_drain_busy", 64'(a_clr_busy), 64'(1));
        reset = 1'b1;
        #1;
        check("rd_rst_in_ready", 64'(a_in_ready), 64'(0));
        check("rd_rst_busy", 64'(a_clr_busy), 64'(0));
        step();
        reset = 1'b0;
        #1;
        check("rd_rel_in_ready", 64'(a_in_ready), 64'(1));
        check("rd_rel_busy", 64'(a_clr_busy), 64'(0));
        step();
        read_a("rd_c0", 5'd0, 32'd0);
        read_a("rd_tot", 5'd16, 32'd0);
        check("rd_sat", 64'(a_sat_flags), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
